// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: handshake states,
// default abort limit and the opcode field position inside the instruction.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } AccessState;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TIMER_W         = 8;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;

endpackage

// File: rtl/access_timer.sv
// Wait-cycle counter for an outstanding memory request; expired marks the
// cycle in which the request has been waiting TIMEOUT cycles.
module access_timer
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    // Clear wins over enable so a finished access always restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TIMER_W'(TIMEOUT));

endmodule

// File: rtl/mem_access_unit.sv
// Converts the controller's memory strobes into a req/ack transaction with a
// variable-latency memory, owns IR and MDR, and stalls the controller meanwhile.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ior_d,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic [5:0]        op,
    output logic              stall,
    output logic              bus_err
);

    AccessState state;
    AccessState nextState;

    logic acc;
    logic issue;
    logic ackSeen;
    logic timedOut;
    logic loadIr;
    logic expired;

    assign acc = mem_read | mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // DONE never looks at the strobes, so a request held by the controller
    // through its advance cycle is only reissued once we are back in IDLE.
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        issue     = 1'b0;
        ackSeen   = 1'b0;
        timedOut  = 1'b0;
        case (state)
            IDLE: begin
                stall = acc;
                if (acc) begin
                    issue     = 1'b1;
                    nextState = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    ackSeen   = 1'b1;
                    nextState = DONE;
                end else if (expired) begin
                    timedOut  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // The issue edge already counts as the first wait cycle, so the count
    // equals the REQ cycle number and expires in REQ cycle TIMEOUT.
    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) waitTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == DONE),
        .enable  (issue | (state == REQ)),
        .expired (expired)
    );

    // Address, direction and store data are captured once at issue so the
    // controller may move pc/alu_out/wdata while the memory is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            loadIr    <= 1'b0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write;
            mem_addr  <= ior_d ? alu_out : pc;
            mem_wdata <= wdata;
            loadIr    <= ir_write & ~mem_write;
        end else if (ackSeen || timedOut) begin
            mem_req   <= 1'b0;
        end
    end

    // A write that also carried MemRead never touches MDR or IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr <= '0;
            ir  <= '0;
        end else if (ackSeen && !mem_we) begin
            mdr <= mem_rdata;
            if (loadIr) begin
                ir <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (timedOut) begin
            bus_err <= 1'b1;
        end
    end

    assign op = ir[OP_HI:OP_LO];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model is checked
// every cycle, plus literal expectations for each scripted access.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 4;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              mem_read  = 1'b0;
    logic              mem_write = 1'b0;
    logic              ior_d     = 1'b0;
    logic              ir_write  = 1'b0;
    logic [ADDR_W-1:0] pc        = '0;
    logic [ADDR_W-1:0] alu_out   = '0;
    logic [DATA_W-1:0] wdata     = '0;
    logic              mem_ack   = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;
    logic [5:0]        op;
    logic              stall;
    logic              bus_err;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ior_d     (ior_d),
        .ir_write  (ir_write),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .mdr       (mdr),
        .op        (op),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Transaction model: an access is in flight for at most TO cycles after
    // issue, then one completion cycle follows before new strobes are accepted.
    bit          mBusy   = 1'b0;
    bit          mDone   = 1'b0;
    bit          mFetch  = 1'b0;
    bit          mWe     = 1'b0;
    bit          mErr    = 1'b0;
    int          mWaited = 0;
    logic [31:0] mAddr   = '0;
    logic [31:0] mWdata  = '0;
    logic [31:0] mIr     = '0;
    logic [31:0] mMdr    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy   <= 1'b0;
            mDone   <= 1'b0;
            mFetch  <= 1'b0;
            mWe     <= 1'b0;
            mErr    <= 1'b0;
            mWaited <= 0;
            mAddr   <= '0;
            mWdata  <= '0;
            mIr     <= '0;
            mMdr    <= '0;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (mBusy) begin
            mWaited <= mWaited + 1;
            if (mem_ack) begin
                mBusy <= 1'b0;
                mDone <= 1'b1;
                if (!mWe) begin
                    mMdr <= mem_rdata;
                    if (mFetch) mIr <= mem_rdata;
                end
            end else if (mWaited + 1 >= TO) begin
                mBusy <= 1'b0;
                mDone <= 1'b1;
                mErr  <= 1'b1;
            end
        end else if (mem_read || mem_write) begin
            mBusy   <= 1'b1;
            mWaited <= 0;
            mWe     <= mem_write;
            mFetch  <= ir_write && !mem_write;
            mAddr   <= ior_d ? alu_out : pc;
            mWdata  <= wdata;
        end
    end

    always @(negedge clk) begin
        checkOutput("stall", stall, mBusy || (!mDone && (mem_read || mem_write)));
        checkOutput("mem_req", mem_req, mBusy);
        checkOutput("bus_err", bus_err, mErr);
        checkOutput("ir", ir, mIr);
        checkOutput("mdr", mdr, mMdr);
        checkOutput("op", op, mIr[31:26]);
        if (mBusy) begin
            checkOutput("mem_we", mem_we, mWe);
            checkOutput("mem_addr", mem_addr, mAddr);
            checkOutput("mem_wdata", mem_wdata, mWdata);
        end
    end

    // Drives one access and acks it in REQ cycle ackAt (0 = never); returns
    // once the unit releases the stall, optionally leaving the strobes high.
    task automatic applyStimulus(
        input  logic        rd,
        input  logic        wr,
        input  logic        iord,
        input  logic        irw,
        input  logic [31:0] pcV,
        input  logic [31:0] aluV,
        input  logic [31:0] wdV,
        input  int          ackAt,
        input  logic [31:0] rdataV,
        input  bit          hold,
        output int          stallHigh,
        output int          reqCycles,
        output logic        weSeen,
        output logic [31:0] addrSeen,
        output logic [31:0] wdataSeen
    );
        bit done;
        int guard;
        stallHigh = 0;
        reqCycles = 0;
        weSeen    = 1'b0;
        addrSeen  = '0;
        wdataSeen = '0;
        done      = 1'b0;
        guard     = 0;
        @(negedge clk);
        #1;
        mem_read  = rd;
        mem_write = wr;
        ior_d     = iord;
        ir_write  = irw;
        pc        = pcV;
        alu_out   = aluV;
        wdata     = wdV;
        #1;
        if (stall) stallHigh++;
        while (!done && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
            mem_ack = 1'b0;
            if (mem_req) begin
                reqCycles++;
                if (reqCycles == 1) begin
                    weSeen    = mem_we;
                    addrSeen  = mem_addr;
                    wdataSeen = mem_wdata;
                    pc        = $urandom;
                    alu_out   = $urandom;
                    wdata     = $urandom;
                end
                if (reqCycles == ackAt) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdataV;
                end
            end
            if (stall) begin
                stallHigh++;
            end else begin
                done = 1'b1;
                if (!hold) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    ir_write  = 1'b0;
                end
            end
        end
        checkOutput("access_completes", done, 1'b1);
    endtask

    initial begin
        int          stallHigh;
        int          reqCycles;
        logic        weSeen;
        logic [31:0] addrSeen;
        logic [31:0] wdataSeen;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        checkOutput("reset_mem_req", mem_req, 1'b0);
        checkOutput("reset_ir", ir, 32'h0);
        checkOutput("reset_op", op, 32'h0);
        checkOutput("reset_bus_err", bus_err, 1'b0);
        checkOutput("reset_stall", stall, 1'b0);
        #1 rst_n = 1'b1;

        $display("[TB] instruction fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 2, 32'h8C220004,
                      1'b0, stallHigh, reqCycles, weSeen, addrSeen, wdataSeen);
        checkOutput("fetch_addr", addrSeen, 32'h40);
        checkOutput("fetch_stall_cycles", stallHigh, 3);
        #2;
        checkOutput("fetch_ir", ir, 32'h8C220004);
        checkOutput("fetch_mdr", mdr, 32'h8C220004);
        checkOutput("fetch_op", op, 32'h23);

        $display("[TB] load");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 1, 32'hDEADBEEF,
                      1'b0, stallHigh, reqCycles, weSeen, addrSeen, wdataSeen);
        checkOutput("load_addr", addrSeen, 32'h100);
        checkOutput("load_we", weSeen, 1'b0);
        checkOutput("load_total_cycles", stallHigh + 1, 3);
        checkOutput("load_mdr", mdr, 32'hDEADBEEF);
        checkOutput("load_ir_kept", ir, 32'h8C220004);

        $display("[TB] store with both strobes");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h48, 32'h200, 32'h1234, 1, 32'hFFFFFFFF,
                      1'b0, stallHigh, reqCycles, weSeen, addrSeen, wdataSeen);
        checkOutput("store_we", weSeen, 1'b1);
        checkOutput("store_addr", addrSeen, 32'h200);
        checkOutput("store_wdata", wdataSeen, 32'h1234);
        checkOutput("store_mdr_kept", mdr, 32'hDEADBEEF);
        checkOutput("store_ir_kept", ir, 32'h8C220004);

        $display("[TB] timeout");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h4C, 32'h300, 32'h0, 0, 32'h0,
                      1'b0, stallHigh, reqCycles, weSeen, addrSeen, wdataSeen);
        checkOutput("timeout_req_cycles", reqCycles, TO);
        checkOutput("timeout_bus_err", bus_err, 1'b1);
        checkOutput("timeout_mdr_kept", mdr, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h304, 32'h0, 1, 32'hCAFEF00D,
                      1'b0, stallHigh, reqCycles, weSeen, addrSeen, wdataSeen);
        checkOutput("bus_err_sticky", bus_err, 1'b1);
        checkOutput("after_timeout_mdr", mdr, 32'hCAFEF00D);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h54, 32'h400, 32'h0, 1, 32'h11111111,
                      1'b1, stallHigh, reqCycles, weSeen, addrSeen, wdataSeen);
        checkOutput("done_no_reissue", mem_req, 1'b0);
        checkOutput("done_stall_low", stall, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h58, 32'h404, 32'h0, 2, 32'h22222222,
                      1'b0, stallHigh, reqCycles, weSeen, addrSeen, wdataSeen);
        checkOutput("second_req_cycles", reqCycles, 2);
        checkOutput("second_addr", addrSeen, 32'h404);
        checkOutput("second_mdr", mdr, 32'h22222222);

        $display("[TB] reset mid-access");
        @(negedge clk);
        #1;
        mem_read = 1'b1;
        ir_write = 1'b1;
        ior_d    = 1'b0;
        pc       = 32'h80;
        @(negedge clk);
        #1;
        checkOutput("pre_reset_req", mem_req, 1'b1);
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        mem_read = 1'b0;
        ir_write = 1'b0;
        #1;
        checkOutput("async_req_drop", mem_req, 1'b0);
        checkOutput("async_ir_clear", ir, 32'h0);
        checkOutput("async_mdr_clear", mdr, 32'h0);
        checkOutput("async_bus_err_clear", bus_err, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        #1;
        mem_ack = 1'b0;
        checkOutput("late_ack_req", mem_req, 1'b0);
        checkOutput("late_ack_mdr", mdr, 32'h0);
        checkOutput("late_ack_ir", ir, 32'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
